sprite_motion_ctrl: RTL and testbench
=====================================

Name: sprite_motion_ctrl

Overview:
- Frame-rate motion controller for the LCD sprite/rectangle datapath in the hackathon top.
- Sequences the sprite position once per frame strobe from the 30 Hz strobe generator, bouncing it off the screen edges.
- Owns the run/pause/restart state machine and the speed setting driven by board keys.
- Exports the sprite origin, speed and bounce count to the pixel-compare logic, the LEDs and the seven-segment display.

Parameters:
- SCREEN_W, 480, visible width in pixels
- SCREEN_H, 272, visible height in pixels
- SPRITE_W, 50, sprite width; max x = SCREEN_W - SPRITE_W
- SPRITE_H, 100, sprite height; max y = SCREEN_H - SPRITE_H
- START_X, 100, x origin after reset/restart
- START_Y, 100, y origin after reset/restart
- STEP_MAX, 7, maximum pixels moved per pulse

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- pulse  input  1  one-cycle frame strobe
- key_start  input  1  level; rising edge = start/restart
- key_pause  input  1  level; rising edge = toggle pause
- key_faster  input  1  level; rising edge = speed+1
- key_slower  input  1  level; rising edge = speed-1
- sprite_x  output  9  sprite left edge
- sprite_y  output  9  sprite top edge
- speed  output  3  current step, 1..STEP_MAX
- state  output  2  0=IDLE, 1=RUN, 2=PAUSE
- bounce_cnt  output  8  edge hits since start, saturating
- running  output  1  state == RUN

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- All outputs are registered.
- Reset values: sprite_x=START_X, sprite_y=START_Y, speed=1, state=IDLE, bounce_cnt=0, running=0. Internal dx=+1, dy=+1; key history registers = 0.
- Key edges: event = key & ~key_prev, with key_prev registered every cycle. A held key gives exactly one event.
- Keys are assumed already synchronous; the block adds no synchronizer.
- IDLE: position is held at START. A start event -> RUN.
- RUN:
  - A start event -> IDLE; position = START, dx=dy=+1, bounce_cnt=0, speed is preserved.
  - A pause event -> PAUSE.
  - Otherwise, on pulse: move both axes by speed.
- PAUSE:
  - A pause event -> RUN.
  - A start event -> IDLE, with the same restart actions as in RUN.
  - pulse is ignored.
- Priority within one cycle: start > pause > pulse. A pulse coinciding with a start or pause event produces no movement.
- Axis step, evaluated in 10-bit arithmetic (no wrap):
  - Moving +: if p + speed >= MAX then p=MAX, direction flips to -, hit=1; else p = p + speed.
  - Moving -: if p <= speed then p=0, direction flips to +, hit=1; else p = p - speed.
  - p exactly at the limit bounces the same way.
- bounce_cnt increments by 1 when either axis hits. A corner hit on both axes in the same pulse counts once. The count saturates at 255.
- Speed events are accepted in any state.
  - faster: speed = min(speed+1, STEP_MAX).
  - slower: speed = max(speed-1, 1).
  - faster and slower events in the same cycle: no change.
  - A speed change made in the same cycle as a pulse takes effect on the next pulse (the move uses the old speed).
- Latency: outputs reflect a pulse or event one clock after the cycle in which it is sampled.
- Reset mid-motion returns every register to its reset value in the next cycle, regardless of state.

Decomposition:
- Package sprite_pkg holds:
  - enum state_t {IDLE, RUN, PAUSE} (2-bit)
  - SCREEN_W/SCREEN_H constants
  - 10-bit coord_ext_t typedef for step arithmetic
- Sub-module sprite_axis_step: combinational single-axis step/bounce. Inputs are pos, dir, step and limit; outputs are next pos, next dir and hit. Instantiated twice (x with SCREEN_W-SPRITE_W, y with SCREEN_H-SPRITE_H).

Test Plan:
- Reset -> sprite_x=100, sprite_y=100, speed=1, state=0, bounce_cnt=0. Pulses while IDLE -> no change.
- Start edge, then 5 pulses at speed 1 -> sprite_x=105, sprite_y=105, running=1. Holding key_start high for 100 cycles -> only one transition.
- Right-edge bounce: speed 7, x=428 moving + -> pulse gives x=430, bounce_cnt+1; next pulse gives x=423.
- Corner: x=429, y=171, both moving +, speed 1 -> x=430, y=172, bounce_cnt increments by exactly 1; next pulse gives x=429, y=171.
- Pause edge in the same cycle as a pulse -> position unchanged, state=PAUSE. 10 pulses -> still unchanged. Pause edge -> RUN and motion resumes.
- Speed clamp: 10 faster edges -> speed=7; 10 slower edges -> speed=1; simultaneous faster+slower -> unchanged. Reset asserted mid-RUN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite motion controller and its axis stepper.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int SCREEN_W = 480;
    localparam int SCREEN_H = 272;

    // One extra bit of headroom so pos + step can never wrap before the limit compare.
    typedef logic [9:0] coord_ext_t;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/sprite_axis_step.sv
// Combinational single-axis step with clamp-and-bounce at 0 and at limit.
module sprite_axis_step (
    input  logic [8:0] pos,
    input  logic       dir,
    input  logic [2:0] step,
    input  logic [8:0] limit,
    output logic [8:0] pos_next,
    output logic       dir_next,
    output logic       hit
);
    import sprite_pkg::*;

    coord_ext_t pos_ext;
    coord_ext_t step_ext;
    coord_ext_t limit_ext;

    assign pos_ext   = coord_ext_t'(pos);
    assign step_ext  = coord_ext_t'(step);
    assign limit_ext = coord_ext_t'(limit);

    always_comb begin
        pos_next = pos;
        dir_next = dir;
        hit      = 1'b0;
        if (dir == DIR_POS) begin
            if (pos_ext + step_ext >= limit_ext) begin
                pos_next = limit;
                dir_next = DIR_NEG;
                hit      = 1'b1;
            end else begin
                pos_next = pos + {6'd0, step};
            end
        end else begin
            // Reaching exactly zero also counts as a bounce.
            if (pos_ext <= step_ext) begin
                pos_next = 9'd0;
                dir_next = DIR_POS;
                hit      = 1'b1;
            end else begin
                pos_next = pos - {6'd0, step};
            end
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Frame-rate sprite motion controller: run/pause/restart FSM, key-driven speed,
// per-pulse bounce motion on both axes and a saturating bounce counter.
module sprite_motion_ctrl #(
    parameter int SCREEN_W = sprite_pkg::SCREEN_W,
    parameter int SCREEN_H = sprite_pkg::SCREEN_H,
    parameter int SPRITE_W = 50,
    parameter int SPRITE_H = 100,
    parameter int START_X  = 100,
    parameter int START_Y  = 100,
    parameter int STEP_MAX = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pulse,
    input  logic       key_start,
    input  logic       key_pause,
    input  logic       key_faster,
    input  logic       key_slower,
    output logic [8:0] sprite_x,
    output logic [8:0] sprite_y,
    output logic [2:0] speed,
    output logic [1:0] state,
    output logic [7:0] bounce_cnt,
    output logic       running
);
    import sprite_pkg::*;

    localparam logic [8:0] MAX_X   = 9'(SCREEN_W - SPRITE_W);
    localparam logic [8:0] MAX_Y   = 9'(SCREEN_H - SPRITE_H);
    localparam logic [8:0] START_X9 = 9'(START_X);
    localparam logic [8:0] START_Y9 = 9'(START_Y);
    localparam logic [2:0] STEP_MAX3 = 3'(STEP_MAX);

    state_t     state_reg, state_next;
    logic [8:0] x_reg, x_next, y_reg, y_next;
    logic       dx_reg, dx_next, dy_reg, dy_next;
    logic [2:0] speed_reg, speed_next;
    logic [7:0] bounce_reg, bounce_next;
    logic       running_reg;
    logic [3:0] key_prev_reg;

    logic [3:0] keys;
    logic [3:0] key_ev;
    logic       start_ev, pause_ev, faster_ev, slower_ev;

    logic [8:0] x_step, y_step;
    logic       dx_step, dy_step, hit_x, hit_y;

    assign keys      = {key_slower, key_faster, key_pause, key_start};
    assign key_ev    = keys & ~key_prev_reg;
    assign start_ev  = key_ev[0];
    assign pause_ev  = key_ev[1];
    assign faster_ev = key_ev[2];
    assign slower_ev = key_ev[3];

    sprite_axis_step u_axis_x (
        .pos      (x_reg),
        .dir      (dx_reg),
        .step     (speed_reg),
        .limit    (MAX_X),
        .pos_next (x_step),
        .dir_next (dx_step),
        .hit      (hit_x)
    );

    sprite_axis_step u_axis_y (
        .pos      (y_reg),
        .dir      (dy_reg),
        .step     (speed_reg),
        .limit    (MAX_Y),
        .pos_next (y_step),
        .dir_next (dy_step),
        .hit      (hit_y)
    );

    always_comb begin
        state_next  = state_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        dx_next     = dx_reg;
        dy_next     = dy_reg;
        bounce_next = bounce_reg;
        speed_next  = speed_reg;

        // Opposing speed keys in the same cycle cancel out.
        if (faster_ev && !slower_ev && speed_reg < STEP_MAX3) begin
            speed_next = speed_reg + 3'd1;
        end else if (slower_ev && !faster_ev && speed_reg > 3'd1) begin
            speed_next = speed_reg - 3'd1;
        end

        case (state_reg)
            IDLE: begin
                if (start_ev) begin
                    state_next = RUN;
                end
            end
            RUN, PAUSE: begin
                if (start_ev) begin
                    state_next  = IDLE;
                    x_next      = START_X9;
                    y_next      = START_Y9;
                    dx_next     = DIR_POS;
                    dy_next     = DIR_POS;
                    bounce_next = 8'd0;
                end else if (pause_ev) begin
                    state_next = (state_reg == RUN) ? PAUSE : RUN;
                end else if (pulse && state_reg == RUN) begin
                    x_next  = x_step;
                    y_next  = y_step;
                    dx_next = dx_step;
                    dy_next = dy_step;
                    if ((hit_x || hit_y) && bounce_reg != 8'hFF) begin
                        bounce_next = bounce_reg + 8'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            x_reg        <= START_X9;
            y_reg        <= START_Y9;
            dx_reg       <= DIR_POS;
            dy_reg       <= DIR_POS;
            speed_reg    <= 3'd1;
            bounce_reg   <= 8'd0;
            running_reg  <= 1'b0;
            key_prev_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            dx_reg       <= dx_next;
            dy_reg       <= dy_next;
            speed_reg    <= speed_next;
            bounce_reg   <= bounce_next;
            running_reg  <= (state_next == RUN);
            key_prev_reg <= keys;
        end
    end

    assign sprite_x   = x_reg;
    assign sprite_y   = y_reg;
    assign speed      = speed_reg;
    assign state      = state_reg;
    assign bounce_cnt = bounce_reg;
    assign running    = running_reg;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed-vector bench for sprite_motion_ctrl with hand-computed expectations.
module tb_sprite_motion_ctrl;

    logic       clock;
    logic       reset;
    logic       pulse;
    logic       key_start;
    logic       key_pause;
    logic       key_faster;
    logic       key_slower;
    logic [8:0] sprite_x;
    logic [8:0] sprite_y;
    logic [2:0] speed;
    logic [1:0] state;
    logic [7:0] bounce_cnt;
    logic       running;

    int checks = 0;
    int errors = 0;

    sprite_motion_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .pulse      (pulse),
        .key_start  (key_start),
        .key_pause  (key_pause),
        .key_faster (key_faster),
        .key_slower (key_slower),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .speed      (speed),
        .state      (state),
        .bounce_cnt (bounce_cnt),
        .running    (running)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %s: observed %0d", tag, obs);
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; outputs are sampled there too.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_pulse();
        pulse = 1'b1;
        tick(1);
        pulse = 1'b0;
        tick(1);
    endtask

    // 0=start, 1=pause, 2=faster, 3=slower: one press-and-release edge
    task automatic press(input int which);
        case (which)
            0: key_start  = 1'b1;
            1: key_pause  = 1'b1;
            2: key_faster = 1'b1;
            default: key_slower = 1'b1;
        endcase
        tick(1);
        key_start  = 1'b0;
        key_pause  = 1'b0;
        key_faster = 1'b0;
        key_slower = 1'b0;
        tick(1);
    endtask

    initial begin
        reset      = 1'b1;
        pulse      = 1'b0;
        key_start  = 1'b0;
        key_pause  = 1'b0;
        key_faster = 1'b0;
        key_slower = 1'b0;
        tick(2);
        chk("reset_x", 16'(sprite_x), 16'd100);
        chk("reset_y", 16'(sprite_y), 16'd100);
        chk("reset_speed", 16'(speed), 16'd1);
        chk("reset_state", 16'(state), 16'd0);
        chk("reset_bounce", 16'(bounce_cnt), 16'd0);
        chk("reset_running", 16'(running), 16'd0);
        reset = 1'b0;

        repeat (3) do_pulse();
        chk("idle_x", 16'(sprite_x), 16'd100);
        chk("idle_y", 16'(sprite_y), 16'd100);
        chk("idle_state", 16'(state), 16'd0);

        key_start = 1'b1;
        tick(1);
        chk("start_state", 16'(state), 16'd1);
        chk("start_running", 16'(running), 16'd1);
        tick(99);
        chk("held_start_state", 16'(state), 16'd1);
        key_start = 1'b0;
        tick(1);

        repeat (5) do_pulse();
        chk("run5_x", 16'(sprite_x), 16'd105);
        chk("run5_y", 16'(sprite_y), 16'd105);
        chk("run5_running", 16'(running), 16'd1);
        do_pulse();
        chk("run6_x", 16'(sprite_x), 16'd106);
        chk("run6_y", 16'(sprite_y), 16'd106);

        repeat (10) press(2);
        chk("faster_clamp", 16'(speed), 16'd7);

        // y bounces at 172 (pulse 10) and at 0 (pulse 35); x climbs 106 -> 428
        repeat (46) do_pulse();
        chk("pre_edge_x", 16'(sprite_x), 16'd428);
        chk("pre_edge_y", 16'(sprite_y), 16'd77);
        chk("pre_edge_bounce", 16'(bounce_cnt), 16'd2);
        do_pulse();
        chk("edge_x", 16'(sprite_x), 16'd430);
        chk("edge_y", 16'(sprite_y), 16'd84);
        chk("edge_bounce", 16'(bounce_cnt), 16'd3);
        do_pulse();
        chk("after_edge_x", 16'(sprite_x), 16'd423);
        chk("after_edge_y", 16'(sprite_y), 16'd91);
        chk("after_edge_bounce", 16'(bounce_cnt), 16'd3);

        key_pause = 1'b1;
        pulse     = 1'b1;
        tick(1);
        key_pause = 1'b0;
        pulse     = 1'b0;
        chk("pause_state", 16'(state), 16'd2);
        chk("pause_x", 16'(sprite_x), 16'd423);
        chk("pause_running", 16'(running), 16'd0);
        tick(1);
        repeat (10) do_pulse();
        chk("paused_x", 16'(sprite_x), 16'd423);
        chk("paused_y", 16'(sprite_y), 16'd91);
        press(1);
        chk("resume_state", 16'(state), 16'd1);
        do_pulse();
        chk("resume_x", 16'(sprite_x), 16'd416);
        chk("resume_y", 16'(sprite_y), 16'd98);

        key_faster = 1'b1;
        key_slower = 1'b1;
        tick(1);
        key_faster = 1'b0;
        key_slower = 1'b0;
        tick(1);
        chk("both_keys_speed", 16'(speed), 16'd7);
        repeat (10) press(3);
        chk("slower_clamp", 16'(speed), 16'd1);

        key_faster = 1'b1;
        pulse      = 1'b1;
        tick(1);
        key_faster = 1'b0;
        pulse      = 1'b0;
        chk("old_speed_x", 16'(sprite_x), 16'd415);
        chk("old_speed_y", 16'(sprite_y), 16'd99);
        chk("new_speed", 16'(speed), 16'd2);
        tick(1);
        do_pulse();
        chk("speed2_x", 16'(sprite_x), 16'd413);
        chk("speed2_y", 16'(sprite_y), 16'd101);
        press(3);

        press(0);
        chk("restart_state", 16'(state), 16'd0);
        chk("restart_x", 16'(sprite_x), 16'd100);
        chk("restart_y", 16'(sprite_y), 16'd100);
        chk("restart_bounce", 16'(bounce_cnt), 16'd0);
        chk("restart_speed", 16'(speed), 16'd1);
        press(0);
        chk("rerun_state", 16'(state), 16'd1);

        // Speed 1 from (100,100): x hits 430 once, y hits 4 times, then a shared corner at pulse 760
        repeat (759) do_pulse();
        chk("pre_corner_x", 16'(sprite_x), 16'd1);
        chk("pre_corner_y", 16'(sprite_y), 16'd171);
        chk("pre_corner_bounce", 16'(bounce_cnt), 16'd5);
        do_pulse();
        chk("corner_x", 16'(sprite_x), 16'd0);
        chk("corner_y", 16'(sprite_y), 16'd172);
        chk("corner_bounce", 16'(bounce_cnt), 16'd6);
        do_pulse();
        chk("post_corner_x", 16'(sprite_x), 16'd1);
        chk("post_corner_y", 16'(sprite_y), 16'd171);
        chk("post_corner_bounce", 16'(bounce_cnt), 16'd6);

        press(2);
        pulse = 1'b1;
        reset = 1'b1;
        tick(1);
        pulse = 1'b0;
        reset = 1'b0;
        chk("midrst_x", 16'(sprite_x), 16'd100);
        chk("midrst_y", 16'(sprite_y), 16'd100);
        chk("midrst_speed", 16'(speed), 16'd1);
        chk("midrst_state", 16'(state), 16'd0);
        chk("midrst_bounce", 16'(bounce_cnt), 16'd0);
        chk("midrst_running", 16'(running), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
